ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain loader that sits directly upstream of the routing tiles' `ccff_head` inputs. It accepts bitstream words over a valid/ready stream and serialises exactly `CHAIN_LEN` bits, MSB first, into the configuration flip-flop chain. It drives a per-bit shift enable that the top level uses to gate the fabric's `prog_clk`. It also counts the ones returned on the chain's `ccff_tail` during the load, so the previously loaded configuration can be checked.

## Interface
- `WORD_W`, default 8: input word width; must be ≥2.
- `CHAIN_LEN`, default 24: total chain bits to load; must be ≥1. The default is 12 size-2 mux memories × 2 bits.
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the counters.
- `prog_clk` in 1: the only clock; the whole block is on its rising edge.
- `prog_reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a load.
- `in_data` in `WORD_W`: bitstream word; bit `[WORD_W-1]` is shifted first.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts the word this cycle.
- `ccff_head` out 1: serial bit to the chain head.
- `ccff_shift_en` out 1: the chain advances on this cycle's rising edge.
- `ccff_tail` in 1: serial bit returned from the chain end.
- `busy` out 1: a load is in progress.
- `done` out 1: `CHAIN_LEN` bits have been loaded.
- `bit_count` out `CNT_W`: bits shifted in the current or last load.
- `tail_ones` out `CNT_W`: number of `ccff_tail`=1 samples taken on shift cycles.

## Operation
- **State machine.** The FSM has three states: IDLE, SHIFT, DONE.
- **Reset.** Reset forces IDLE. All outputs are 0, the counters are 0, and the holding register and shift register are empty.
- **Start.**
  - IDLE→SHIFT or DONE→SHIFT on `start`.
  - The same edge clears `bit_count`, `tail_ones`, the words-accepted counter, the holding register and the shift register.
  - `start` is ignored in SHIFT.
- **Word count.** Words needed: `NW = ceil(CHAIN_LEN/WORD_W)`.
- **Input handshake.**
  - `in_ready = (state==SHIFT) && hold_empty && (words_accepted < NW)`.
  - A transfer occurs when `in_valid && in_ready`; the word is written to the holding register.
  - `in_valid` is don't-care when `in_ready`=0. No word is ever accepted in IDLE or DONE.
- **Hold→shift transfer.**
  - The holding register moves to the shift register on the edge where the hold is full and either the shift register is empty, or it holds exactly one bit and `ccff_shift_en`=1. The second case gives back-to-back words with no bubble.
  - The hold becomes empty on that edge. It may accept a new word on the following cycle.
  - The shift-register bit count loaded is `WORD_W`, except for the final word (the NW-th). That word loads `CHAIN_LEN-(NW-1)*WORD_W` bits, taken from its MSBs; its remaining LSBs are discarded.
- **Shift cycle.**
  - `ccff_shift_en = (state==SHIFT) && shreg_count!=0`.
  - `ccff_head` = shift-register MSB.
  - Both outputs are decoded only from flops; there is no combinational path from any input.
  - On each shift edge: shift left, `shreg_count` decrements, `bit_count` increments.
  - `tail_ones` increments if `ccff_tail`=1 on a cycle with `ccff_shift_en`=1.
- **Completion.** On the edge where `bit_count` becomes `CHAIN_LEN`, go SHIFT→DONE.
- **Status outputs.**
  - `busy` = (state==SHIFT).
  - `done` = (state==DONE); it holds until `start` or reset.
- **Underflow.** If the hold and shift register are both empty in SHIFT, `ccff_shift_en`=0. The chain holds and the loader waits indefinitely; no timeout.
- **Reset mid-load.** The load is aborted; `ccff_shift_en`=0 from the next cycle. The chain keeps whatever partial contents it has.

## Timing
- `start` sampled at edge k:
  - `busy`=1 from cycle k+1.
  - `in_ready`=1 from cycle k+1.
- Word accepted at edge c:
  - The hold is full in cycle c+1.
  - The transfer happens at edge c+1 if the shift register is empty.
  - The first `ccff_shift_en`=1 is in cycle c+2.
- With `in_valid` held at 1 continuously:
  - `ccff_shift_en` is 1 for exactly `CHAIN_LEN` consecutive cycles.
  - `done`=1 in the cycle after the last shift cycle.
- `ccff_head` and `ccff_shift_en` change only on `prog_clk` edges. The fabric samples `ccff_head` on the same edge where the loader advances.
- Simultaneous `start` and `prog_reset`: reset wins.

## Test plan
- **Reset.** Assert `prog_reset` for 2 cycles with `in_valid`=1 and `start`=1 → all outputs 0, `in_ready`=0, and no `ccff_shift_en` pulse for 5 cycles afterwards.
- **Default load, back-to-back.** CHAIN_LEN=24, WORD_W=8, words 0xA5, 0x3C, 0xF0 with `in_valid` always 1 → `ccff_head` on the 24 consecutive shift cycles is 10100101 00111100 11110000; `done`=1 one cycle after; `bit_count`=24; exactly 3 handshakes.
- **Partial last word.** CHAIN_LEN=20, WORD_W=8, words 0xFF, 0x00, 0x9F → 20 shift cycles with serial stream 11111111 00000000 1001; low nibble 0xF discarded; `in_ready` never high again.
- **Underflow stall.** Withhold `in_valid` for 10 cycles between word 1 and word 2 → `ccff_shift_en`=0 for the gap; `bit_count` holds at 8; load then completes correctly with 24 shifts total.
- **Readback.** Chain model preloaded with 0xA53CF0, then reload → `tail_ones`=12. Start a second load → `tail_ones` cleared to 0 at the start edge, and counts the ones of the first load as they emerge.
- **Abort and restart.** `prog_reset` after 13 shifts, then `start` → `bit_count` restarts at 0, 24 fresh shifts, `done`=1. A `start` pulse issued mid-SHIFT is ignored (no counter clear).

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Purpose:
//   Loads a configuration flip-flop chain from a stream of bitstream words.
//   Each load serialises exactly CHAIN_LEN bits, MSB first, onto ccff_head.
//   ccff_shift_en marks every cycle in which the chain advances; the top level
//   uses it to gate prog_clk. While loading, the loader also counts the ones
//   returned on ccff_tail, so the configuration that was in the chain before
//   the load can be checked.
//
// Parameters:
//   WORD_W     input word width (>= 2)
//   CHAIN_LEN  number of chain bits loaded per load (>= 1)
//   CNT_W      width of bit_count / tail_ones
//
// Ports:
//   prog_clk       clock; everything is on its rising edge
//   prog_reset     synchronous active-high reset
//   start          one-cycle load request (honoured in IDLE and DONE)
//   in_data        bitstream word; bit [WORD_W-1] is shifted first
//   in_valid       in_data is valid
//   in_ready       a word is accepted this cycle when in_valid is also 1
//   ccff_head      serial bit to the chain head
//   ccff_shift_en  the chain advances on this cycle's rising edge
//   ccff_tail      serial bit returned from the chain end
//   busy           a load is in progress
//   done           the last load completed; held until start or reset
//   bit_count      bits shifted in the current or last load
//   tail_ones      ones seen on ccff_tail during shift cycles
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 24,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [CNT_W-1:0]  tail_ones
);

  // Words per load, and the number of bits used from the final word.
  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
  localparam int SC_W      = $clog2(WORD_W + 1);
  localparam int WA_W      = $clog2(NW + 1);

  localparam logic [SC_W-1:0]  SC_FULL   = SC_W'(WORD_W);
  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(LAST_BITS);
  localparam logic [SC_W-1:0]  SC_ONE    = SC_W'(1);
  localparam logic [SC_W-1:0]  SC_ZERO   = '0;
  localparam logic [WA_W-1:0]  WA_NW     = WA_W'(NW);
  localparam logic [WA_W-1:0]  WA_ONE    = WA_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q,      state_d;
  logic [WORD_W-1:0] hold_q,       hold_d;
  logic              hold_full_q,  hold_full_d;
  logic [WORD_W-1:0] shreg_q,      shreg_d;
  logic [SC_W-1:0]   shreg_cnt_q,  shreg_cnt_d;
  logic [WA_W-1:0]   words_acc_q,  words_acc_d;
  logic [CNT_W-1:0]  bit_count_q,  bit_count_d;
  logic [CNT_W-1:0]  tail_ones_q,  tail_ones_d;

  logic              shift_en;
  logic              accept;
  logic              hold_to_shreg;
  logic              last_word;
  logic [WORD_W-1:0] last_mask;

  // Keeps only the MSBs of the final word that still belong to the chain; the
  // discarded LSBs are zeroed so ccff_head idles low after the last shift.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_last_mask
      assign last_mask[gi] = (gi >= WORD_W - LAST_BITS) ? 1'b1 : 1'b0;
    end
  endgenerate

  // All handshake/shift decodes come from flops only, so ccff_head and
  // ccff_shift_en never see a combinational path from an input.
  assign shift_en = (state_q == S_SHIFT) && (shreg_cnt_q != SC_ZERO);
  assign in_ready = (state_q == S_SHIFT) && !hold_full_q && (words_acc_q < WA_NW);
  assign accept   = in_valid && in_ready;

  // The hold refills the shift register either when it is empty or on the
  // very edge its last bit leaves, which keeps back-to-back words bubble-free.
  assign hold_to_shreg = (state_q == S_SHIFT) && hold_full_q &&
                         ((shreg_cnt_q == SC_ZERO) ||
                          ((shreg_cnt_q == SC_ONE) && shift_en));

  // The hold only ever contains the most recently accepted word, so it is the
  // final word exactly when all NW words have been accepted.
  assign last_word = (words_acc_q == WA_NW);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    shreg_cnt_d = shreg_cnt_q;
    words_acc_d = words_acc_q;
    bit_count_d = bit_count_q;
    tail_ones_d = tail_ones_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_SHIFT;
          hold_d      = '0;
          hold_full_d = 1'b0;
          shreg_d     = '0;
          shreg_cnt_d = '0;
          words_acc_d = '0;
          bit_count_d = '0;
          tail_ones_d = '0;
        end
      end

      S_SHIFT: begin
        if (accept) begin
          hold_d      = in_data;
          hold_full_d = 1'b1;
          words_acc_d = words_acc_q + WA_ONE;
        end

        if (shift_en) begin
          shreg_d     = shreg_q << 1;
          shreg_cnt_d = shreg_cnt_q - SC_ONE;
          bit_count_d = bit_count_q + CNT_ONE;
          if (ccff_tail) begin
            tail_ones_d = tail_ones_q + CNT_ONE;
          end
          if (bit_count_q == CNT_FINAL) begin
            state_d = S_DONE;
          end
        end

        // A refill on a shift edge replaces the shifted value above.
        if (hold_to_shreg) begin
          hold_full_d = 1'b0;
          if (last_word) begin
            shreg_d     = hold_q & last_mask;
            shreg_cnt_d = SC_LAST;
          end else begin
            shreg_d     = hold_q;
            shreg_cnt_d = SC_FULL;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      shreg_cnt_q <= '0;
      words_acc_q <= '0;
      bit_count_q <= '0;
      tail_ones_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      shreg_cnt_q <= shreg_cnt_d;
      words_acc_q <= words_acc_d;
      bit_count_q <= bit_count_d;
      tail_ones_q <= tail_ones_d;
    end
  end

  assign ccff_shift_en = shift_en;
  assign ccff_head     = shreg_q[WORD_W-1];
  assign busy          = (state_q == S_SHIFT);
  assign done          = (state_q == S_DONE);
  assign bit_count     = bit_count_q;
  assign tail_ones     = tail_ones_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
//
// Two loaders share one clock: dut_a (CHAIN_LEN=24) drives a 24-bit chain
// model whose tail feeds back into it, dut_b (CHAIN_LEN=20) exercises the
// partial final word. Expected ccff_head bits for dut_a are queued when each
// word is handed over and popped by a monitor on every shift cycle.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

  logic       clk = 1'b0;
  logic       prog_reset;

  logic       a_start, a_valid, a_ready, a_head, a_shift_en, a_tail, a_busy, a_done;
  logic [7:0] a_data;
  logic [4:0] a_bit_count, a_tail_ones;

  logic       b_start, b_valid, b_ready, b_head, b_shift_en, b_tail, b_busy, b_done;
  logic [7:0] b_data;
  logic [4:0] b_bit_count, b_tail_ones;

  int n_checks = 0;
  int n_errors = 0;

  bit   exp_q[$];
  int   a_hs = 0;
  int   run_len = 0;
  int   last_run = 0;
  logic prev_done = 1'b0;
  logic prev_shift = 1'b0;

  // Chain model, preloaded with a known previous configuration.
  logic [23:0] chain_q = 24'hA53CF0;

  logic [31:0] b_stream = '0;
  int          b_shifts = 0;
  int          b_hs = 0;

  always #5 clk = ~clk;

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(24)) dut_a (
    .prog_clk(clk), .prog_reset(prog_reset), .start(a_start),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .ccff_head(a_head), .ccff_shift_en(a_shift_en), .ccff_tail(a_tail),
    .busy(a_busy), .done(a_done), .bit_count(a_bit_count), .tail_ones(a_tail_ones)
  );

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut_b (
    .prog_clk(clk), .prog_reset(prog_reset), .start(b_start),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .ccff_head(b_head), .ccff_shift_en(b_shift_en), .ccff_tail(b_tail),
    .busy(b_busy), .done(b_done), .bit_count(b_bit_count), .tail_ones(b_tail_ones)
  );

  assign a_tail = chain_q[23];
  assign b_tail = 1'b0;

  always @(posedge clk) begin
    if (a_shift_en) chain_q <= {chain_q[22:0], a_head};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor for dut_a.
  always @(negedge clk) begin
    if (a_valid && a_ready) a_hs++;
    if (a_shift_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_shift", 1, 0);
      end else begin
        check("ccff_head", {31'd0, a_head}, {31'd0, exp_q.pop_front()});
      end
      run_len++;
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
    if (a_done && !prev_done) check("done_after_last_shift", {31'd0, prev_shift}, 1);
    prev_done  = a_done;
    prev_shift = a_shift_en;
  end

  always @(negedge clk) begin
    if (b_shift_en) begin
      b_stream = {b_stream[30:0], b_head};
      b_shifts++;
    end
    if (b_valid && b_ready) b_hs++;
  end

  // Present a word to dut_a and wait for its handshake; returns just after
  // the accepting edge. in_valid is left high.
  task automatic send_a(input logic [7:0] w);
    bit got = 0;
    @(posedge clk); #1;
    a_data  = w;
    a_valid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (a_ready) begin
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
        got = 1;
        @(posedge clk); #1;
      end
    end
    check("send_timeout", {31'd0, got}, 1);
  endtask

  task automatic wait_done_a();
    bit got = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (a_done) got = 1;
    end
    check("done_timeout", {31'd0, got}, 1);
    #1;
  endtask

  task automatic wait_bits_a(input logic [4:0] n);
    bit got = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (a_bit_count == n) got = 1;
    end
    check("bit_count_timeout", {31'd0, got}, 1);
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1; a_start = 1'b1;
    @(posedge clk); #1; a_start = 1'b0;
  endtask

  initial begin
    int         hs0;
    bit         got;
    logic [7:0] bw [3];
    bw = '{8'hFF, 8'h00, 8'h9F};

    // ---------------- Reset with start/in_valid asserted ----------------
    prog_reset = 1'b1;
    a_start = 1'b1; a_valid = 1'b1; a_data = 8'hFF;
    b_start = 1'b1; b_valid = 1'b1; b_data = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",       {31'd0, a_busy}, 0);
    check("rst_done",       {31'd0, a_done}, 0);
    check("rst_in_ready",   {31'd0, a_ready}, 0);
    check("rst_shift_en",   {31'd0, a_shift_en}, 0);
    check("rst_head",       {31'd0, a_head}, 0);
    check("rst_bit_count",  {27'd0, a_bit_count}, 0);
    check("rst_tail_ones",  {27'd0, a_tail_ones}, 0);
    check("rst_b_in_ready", {31'd0, b_ready}, 0);
    @(posedge clk); #1;
    prog_reset = 1'b0;
    a_start = 1'b0; a_valid = 1'b0;
    b_start = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_shift", {31'd0, a_shift_en}, 0);
      check("post_rst_idle",     {31'd0, a_busy}, 0);
    end

    // ---------------- Default load, back-to-back ----------------
    hs0 = a_hs;
    pulse_start_a();
    @(negedge clk);
    check("start_busy",     {31'd0, a_busy}, 1);
    check("start_in_ready", {31'd0, a_ready}, 1);
    send_a(8'hA5);
    send_a(8'h3C);
    send_a(8'hF0);
    wait_done_a();
    check("b2b_run_len",   last_run, 24);
    check("b2b_bit_count", {27'd0, a_bit_count}, 24);
    check("b2b_handshakes", a_hs - hs0, 3);
    check("b2b_queue_left", exp_q.size(), 0);
    check("b2b_busy",      {31'd0, a_busy}, 0);
    check("readback_ones", {27'd0, a_tail_ones}, 12);
    @(posedge clk); #1; a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_holds", {31'd0, a_done}, 1);
    end

    // ---------------- Underflow stall + readback of previous load ----------------
    hs0 = a_hs;
    pulse_start_a();
    @(negedge clk);
    check("restart_tail_clear", {27'd0, a_tail_ones}, 0);
    check("restart_bits_clear", {27'd0, a_bit_count}, 0);
    check("restart_done_clear", {31'd0, a_done}, 0);
    send_a(8'hA5);
    a_valid = 1'b0;
    @(negedge clk);
    check("first_shift_c1", {31'd0, a_shift_en}, 0);
    @(negedge clk);
    check("first_shift_c2", {31'd0, a_shift_en}, 1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_no_shift",  {31'd0, a_shift_en}, 0);
      check("stall_bit_count", {27'd0, a_bit_count}, 8);
    end
    check("stall_tail_ones", {27'd0, a_tail_ones}, 4);
    send_a(8'h3C);
    send_a(8'hF0);
    wait_done_a();
    check("stall_bit_count_end", {27'd0, a_bit_count}, 24);
    check("stall_last_run",      last_run, 16);
    check("stall_tail_ones_end", {27'd0, a_tail_ones}, 12);
    check("stall_handshakes",    a_hs - hs0, 3);
    check("stall_queue_left",    exp_q.size(), 0);
    @(posedge clk); #1; a_valid = 1'b0;

    // ---------------- Abort with reset, then restart ----------------
    pulse_start_a();
    send_a(8'hA5);
    send_a(8'h3C);
    wait_bits_a(5'd12);
    @(posedge clk); #1;
    prog_reset = 1'b1;
    @(posedge clk); #1;
    prog_reset = 1'b0;
    a_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_shift_en",  {31'd0, a_shift_en}, 0);
    check("abort_busy",      {31'd0, a_busy}, 0);
    check("abort_bit_count", {27'd0, a_bit_count}, 0);
    check("abort_in_ready",  {31'd0, a_ready}, 0);
    hs0 = a_hs;
    pulse_start_a();
    send_a(8'hA5);
    send_a(8'h3C);
    send_a(8'hF0);
    // Mid-load start must be ignored; in_valid stays high with a stale word.
    pulse_start_a();
    @(negedge clk);
    check("midstart_busy",    {31'd0, a_busy}, 1);
    check("midstart_no_clear", {31'd0, (a_bit_count != 5'd0)}, 1);
    wait_done_a();
    check("again_run_len",    last_run, 24);
    check("again_bit_count",  {27'd0, a_bit_count}, 24);
    check("again_handshakes", a_hs - hs0, 3);
    check("again_queue_left", exp_q.size(), 0);
    @(posedge clk); #1; a_valid = 1'b0;

    // ---------------- Partial last word (CHAIN_LEN=20) ----------------
    @(posedge clk); #1; b_start = 1'b1;
    @(posedge clk); #1; b_start = 1'b0; b_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_data = bw[k];
      got = 0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        if (b_ready) begin
          got = 1;
          @(posedge clk); #1;
        end
      end
      check("b_send_timeout", {31'd0, got}, 1);
    end
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (b_done) got = 1;
    end
    check("b_done_timeout", {31'd0, got}, 1);
    #1;
    check("b_stream",    b_stream & 32'h000F_FFFF, 32'h000F_F009);
    check("b_shifts",    b_shifts, 20);
    check("b_bit_count", {27'd0, b_bit_count}, 20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b_no_ready_after", {31'd0, b_ready}, 0);
    end
    check("b_handshakes", b_hs, 3);
    b_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
